pc_control_unit: RTL and testbench

PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

---
 rtl/pc_control_unit_pkg.sv | 14 +
 rtl/pc_control_unit_ras.sv | 51 +++++
 rtl/pc_control_unit.sv | 113 +++++++++++
 tb/tb_pc_control_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_control_unit_pkg.sv
// Shared processor encodings: fetch-stage PC select and PC control FSM states.
// Pure constants, no logic; no latency or flow control of its own.
package pc_control_unit_pkg;

    localparam logic [1:0] PC_NPC  = 2'b00;
    localparam logic [1:0] PC_JIMM = 2'b01;
    localparam logic [1:0] PC_IIMM = 2'b10;
    localparam logic [1:0] PC_RET  = 2'b11;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_STALL    = 2'b01;
    localparam logic [1:0] ST_REDIRECT = 2'b10;

endpackage

// File: rtl/pc_control_unit_ras.sv
// Circular return-address stack; push/pop take effect at the clock edge and top is combinational.
// No backpressure: a push when full overwrites the oldest entry, a pop when empty is ignored.
module return_address_stack
    import pc_control_unit_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  top_idx;

    // ptr is the next write slot; when full it also addresses the oldest entry.
    assign top_idx = ptr - PTR_W'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(RAS_DEPTH));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (!full) cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr <= top_idx;
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Contents are not reset: an empty count marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= din;
    end

endmodule

// File: rtl/pc_control_unit.sv
// PC select / IF-ID control FSM with return-address stack; redirect costs exactly one bubble.
// Load-use stall holds PC and IF/ID (control events ignored while stalled).
module pc_control_unit
    import pc_control_unit_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              dec_jump,
    input  logic              dec_call,
    input  logic              dec_ret,
    input  logic              dec_branch,
    input  logic              branch_taken,
    input  logic              load_use_stall,
    input  logic [ADDR_W-1:0] npc_in,
    output logic [1:0]        PCsrc,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [ADDR_W-1:0] ReturnAddress,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              ret_underflow
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ctrl_ev;
    logic       ras_push;
    logic       ras_pop;
    logic       ras_full;

    assign ctrl_ev = dec_valid & (dec_jump | dec_call | dec_ret | (dec_branch & branch_taken));

    // Reset gates the combinational outputs so they take reset values immediately.
    always_comb begin
        state_nxt     = state;
        PCsrc         = PC_NPC;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ret_underflow = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    if (load_use_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        state_nxt  = ST_STALL;
                    end else if (ctrl_ev) begin
                        if (dec_ret) begin
                            if (ras_empty) begin
                                ret_underflow = 1'b1;
                            end else begin
                                PCsrc      = PC_RET;
                                ras_pop    = 1'b1;
                                ifid_flush = 1'b1;
                                state_nxt  = ST_REDIRECT;
                            end
                        end else begin
                            ifid_flush = 1'b1;
                            state_nxt  = ST_REDIRECT;
                            if (dec_call) begin
                                PCsrc    = PC_JIMM;
                                ras_push = 1'b1;
                            end else if (dec_jump) begin
                                PCsrc = PC_JIMM;
                            end else begin
                                PCsrc = PC_IIMM;
                            end
                        end
                    end
                end
                ST_STALL: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (!load_use_stall) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            ras_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ras_push && ras_full) ras_overflow <= 1'b1;
        end
    end

    return_address_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk  (clk),
        .reset(reset),
        .push (ras_push),
        .pop  (ras_pop),
        .din  (npc_in),
        .top  (ReturnAddress),
        .empty(ras_empty),
        .full (ras_full)
    );

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit with an expected-output queue checked each cycle.
module tb_pc_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_valid = 1'b0, dec_jump = 1'b0, dec_call = 1'b0, dec_ret = 1'b0;
    logic        dec_branch = 1'b0, branch_taken = 1'b0, load_use_stall = 1'b0;
    logic [15:0] npc_in = '0;
    logic [1:0]  PCsrc;
    logic        pc_write, ifid_write, ifid_flush;
    logic [15:0] ReturnAddress;
    logic        ras_empty, ras_overflow, ret_underflow;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [1:0]  pcsrc;
        logic        pcw, ifw, fl;
        logic        chk_ra;
        logic [15:0] ra;
        logic        empty, ovf, unf;
    } exp_t;

    exp_t exp_q[$];

    pc_control_unit #(.ADDR_W(16), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_jump      (dec_jump),
        .dec_call      (dec_call),
        .dec_ret       (dec_ret),
        .dec_branch    (dec_branch),
        .branch_taken  (branch_taken),
        .load_use_stall(load_use_stall),
        .npc_in        (npc_in),
        .PCsrc         (PCsrc),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .ReturnAddress (ReturnAddress),
        .ras_empty     (ras_empty),
        .ras_overflow  (ras_overflow),
        .ret_underflow (ret_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, j, c, r, b, t, s, input logic [15:0] npc);
        dec_valid = v; dec_jump = j; dec_call = c; dec_ret = r;
        dec_branch = b; branch_taken = t; load_use_stall = s; npc_in = npc;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] pcsrc,
                              input logic pcw, ifw, fl, chk_ra, input logic [15:0] ra,
                              input logic empty, ovf, unf);
        exp_t e;
        e.tag = tag; e.pcsrc = pcsrc; e.pcw = pcw; e.ifw = ifw; e.fl = fl;
        e.chk_ra = chk_ra; e.ra = ra; e.empty = empty; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Compare combinational outputs mid-cycle, then advance to just after the next edge.
    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        n_assert++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.tag, "PCsrc",         {14'd0, PCsrc},         {14'd0, e.pcsrc});
            cmp(e.tag, "pc_write",      {15'd0, pc_write},      {15'd0, e.pcw});
            cmp(e.tag, "ifid_write",    {15'd0, ifid_write},    {15'd0, e.ifw});
            cmp(e.tag, "ifid_flush",    {15'd0, ifid_flush},    {15'd0, e.fl});
            cmp(e.tag, "ras_empty",     {15'd0, ras_empty},     {15'd0, e.empty});
            cmp(e.tag, "ras_overflow",  {15'd0, ras_overflow},  {15'd0, e.ovf});
            cmp(e.tag, "ret_underflow", {15'd0, ret_underflow}, {15'd0, e.unf});
            if (e.chk_ra) cmp(e.tag, "ReturnAddress", ReturnAddress, e.ra);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n, input logic empty, ovf);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
            expect_out(tag, 2'b00, 1, 1, 0, 0, 16'h0, empty, ovf, 0);
            check_cycle();
        end
    endtask

    logic [15:0] calls [5];

    initial begin
        calls[0] = 16'h2; calls[1] = 16'h4; calls[2] = 16'h6; calls[3] = 16'h8; calls[4] = 16'hA;

        // Reset forces outputs regardless of ret/stall on the inputs.
        #2 reset = 1'b1;
        drive(1, 0, 0, 1, 0, 0, 1, 16'h0);
        expect_out("reset", 2'b00, 1, 1, 0, 1, 16'h0, 1, 0, 0);
        check_cycle();
        reset = 1'b0;

        idle("idle", 5, 1, 0);

        // Call then return.
        drive(1, 0, 1, 0, 0, 0, 0, 16'h0010);
        expect_out("call", 2'b01, 1, 1, 1, 0, 16'h0, 1, 0, 0);
        check_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        expect_out("call_redir", 2'b00, 1, 1, 0, 1, 16'h0010, 0, 0, 0);
        check_cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 16'h0);
        expect_out("ret", 2'b11, 1, 1, 1, 1, 16'h0010, 0, 0, 0);
        check_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        expect_out("ret_redir", 2'b00, 1, 1, 0, 1, 16'h0, 1, 0, 0);
        check_cycle();

        // Load-use stall over a taken branch; branch redirects after release.
        drive(1, 0, 0, 0, 1, 1, 1, 16'h0);
        expect_out("stall1", 2'b00, 0, 0, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();
        expect_out("stall2", 2'b00, 0, 0, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();
        drive(1, 0, 0, 0, 1, 1, 0, 16'h0);
        expect_out("stall_rel", 2'b00, 0, 0, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();
        expect_out("branch", 2'b10, 1, 1, 1, 0, 16'h0, 1, 0, 0);
        check_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        expect_out("branch_redir", 2'b00, 1, 1, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();

        // Not-taken branch and invalid jump are not control events.
        drive(1, 0, 0, 0, 1, 0, 0, 16'h0);
        expect_out("br_nt", 2'b00, 1, 1, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 16'h0);
        expect_out("jump_inv", 2'b00, 1, 1, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();

        // Jump beats branch; a call seen during REDIRECT is ignored.
        drive(1, 1, 0, 0, 1, 1, 0, 16'h0);
        expect_out("jump_pri", 2'b01, 1, 1, 1, 0, 16'h0, 1, 0, 0);
        check_cycle();
        drive(1, 0, 1, 0, 0, 0, 0, 16'h0077);
        expect_out("redir_ign", 2'b00, 1, 1, 0, 0, 16'h0, 1, 0, 0);
        check_cycle();
        idle("no_push", 1, 1, 0);

        // Five calls into a four-deep stack.
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 0, 0, 0, 0, calls[k]);
            expect_out($sformatf("callN%0d", k), 2'b01, 1, 1, 1, 0, 16'h0, (k == 0), 0, 0);
            check_cycle();
            drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
            expect_out($sformatf("callN%0d_redir", k), 2'b00, 1, 1, 0, 1, calls[k], 0, (k == 4), 0);
            check_cycle();
        end
        for (int k = 4; k >= 1; k--) begin
            drive(1, 0, 0, 1, 0, 0, 0, 16'h0);
            expect_out($sformatf("retN%0d", k), 2'b11, 1, 1, 1, 1, calls[k], 0, 1, 0);
            check_cycle();
            drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
            expect_out($sformatf("retN%0d_redir", k), 2'b00, 1, 1, 0, 1,
                       (k > 1) ? calls[k-1] : 16'h0, (k == 1), 1, 0);
            check_cycle();
        end
        drive(1, 0, 0, 1, 0, 0, 0, 16'h0);
        expect_out("ret_under", 2'b00, 1, 1, 0, 1, 16'h0, 1, 1, 1);
        check_cycle();
        idle("after_under", 1, 1, 1);

        // Ret beats call and jump: pop only, no push.
        drive(1, 0, 1, 0, 0, 0, 0, 16'h0030);
        expect_out("call30", 2'b01, 1, 1, 1, 0, 16'h0, 1, 1, 0);
        check_cycle();
        idle("call30_redir", 1, 0, 1);
        drive(1, 1, 1, 1, 1, 1, 0, 16'h0040);
        expect_out("ret_pri", 2'b11, 1, 1, 1, 1, 16'h0030, 0, 1, 0);
        check_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        expect_out("ret_pri_redir", 2'b00, 1, 1, 0, 1, 16'h0, 1, 1, 0);
        check_cycle();

        // Reset during the REDIRECT following a call.
        drive(1, 0, 1, 0, 0, 0, 0, 16'h0050);
        expect_out("call50", 2'b01, 1, 1, 1, 0, 16'h0, 1, 1, 0);
        check_cycle();
        reset = 1'b1;
        drive(1, 0, 0, 1, 0, 0, 1, 16'h0);
        expect_out("reset_redir", 2'b00, 1, 1, 0, 1, 16'h0, 1, 0, 0);
        check_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        expect_out("post_reset", 2'b00, 1, 1, 0, 1, 16'h0, 1, 0, 0);
        check_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
